// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong match referee.
package pong_pkg;

    typedef enum logic [2:0] {
        WAIT_FSYNC  = 3'd0,
        TRACK       = 3'd1,
        PASSING     = 3'd2,
        POINT_PAUSE = 3'd3,
        MATCH_OVER  = 3'd4
    } ref_state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    localparam int VRES     = 720;
    localparam int PADDLE_H = 20;

endpackage

// File: rtl/frame_timer.sv
// Counts fsyncs up to a limit; done pulses on the fsync that reaches the limit.
module frame_timer #(
    parameter int MAX_W = 9
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fsync,
    input  logic [MAX_W-1:0] limit,
    output logic [MAX_W-1:0] count,
    output logic             done
);

    logic [MAX_W:0] count_inc;

    assign count_inc = {1'b0, count} + (MAX_W+1)'(1);
    // Combinational so the owner can leave its state on the same fsync edge.
    assign done = fsync && !clear && (count_inc == {1'b0, limit});

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || done) begin
            count <= '0;
        end else if (fsync) begin
            count <= count_inc[MAX_W-1:0];
        end
    end

endmodule

// File: rtl/pong_referee.sv
// Match referee: detects paddle hits and misses at the check rows, keeps score,
// and sequences the per-point pause and the end-of-match hold.
//
// state       | meaning
// WAIT_FSYNC  | idle until the next frame starts
// TRACK       | watching the two check rows for the object
// PASSING     | object missed a paddle; award once it clears or the frame ends
// POINT_PAUSE | game_over held for PAUSE_FRAMES fsyncs
// MATCH_OVER  | winner reached WIN_SCORE; hold, then clear the scores
module pong_referee
    import pong_pkg::*;
#(
    parameter int VRES              = pong_pkg::VRES,
    parameter int PADDLE_H          = pong_pkg::PADDLE_H,
    parameter int VPOS_W            = 12,
    parameter int SCORE_W           = 4,
    parameter int WIN_SCORE         = 9,
    parameter int PAUSE_FRAMES      = 128,
    parameter int MATCH_HOLD_FRAMES = 256,
    parameter int RALLY_W           = 8
) (
    input  logic                     pixel_clk,
    input  logic                     rst,
    input  logic                     fsync,
    input  logic signed [VPOS_W-1:0] vpos,
    input  logic                     active_obj,
    input  logic                     active_paddle_top,
    input  logic                     active_paddle_bot,
    output logic                     game_over,
    output logic                     match_over,
    output logic [SCORE_W-1:0]       player1_score,
    output logic [SCORE_W-1:0]       player2_score,
    output logic                     point_pulse,
    output logic                     scorer,
    output logic                     serve_dir,
    output logic [RALLY_W-1:0]       rally_cnt
);

    localparam int TIMER_W = $clog2(((PAUSE_FRAMES > MATCH_HOLD_FRAMES) ?
                                     PAUSE_FRAMES : MATCH_HOLD_FRAMES) + 1);
    localparam logic signed [VPOS_W-1:0] ROW_BOT = VPOS_W'(VRES - PADDLE_H);
    localparam logic signed [VPOS_W-1:0] ROW_TOP = VPOS_W'(PADDLE_H);
    localparam logic [SCORE_W-1:0]       WIN     = SCORE_W'(WIN_SCORE);

    ref_state_t          state;
    player_t             pend_scorer;
    logic                at_bot;
    logic                at_top;
    logic [SCORE_W-1:0]  score_nxt;
    logic                timer_clear;
    logic [TIMER_W-1:0]  timer_limit;
    logic [TIMER_W-1:0]  frame_cnt;
    logic                timer_done;

    assign at_bot      = (vpos == ROW_BOT) && active_obj;
    assign at_top      = (vpos == ROW_TOP) && active_obj;
    assign score_nxt   = ((pend_scorer == P1) ? player1_score : player2_score) + SCORE_W'(1);
    assign timer_clear = (state != POINT_PAUSE) && (state != MATCH_OVER);
    assign timer_limit = (state == MATCH_OVER) ? TIMER_W'(MATCH_HOLD_FRAMES) : TIMER_W'(PAUSE_FRAMES);

    frame_timer #(
        .MAX_W (TIMER_W)
    ) u_frame_timer (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .clear     (timer_clear),
        .fsync     (fsync),
        .limit     (timer_limit),
        .count     (frame_cnt),
        .done      (timer_done)
    );

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_FSYNC;
            pend_scorer   <= P1;
            game_over     <= 1'b0;
            match_over    <= 1'b0;
            player1_score <= '0;
            player2_score <= '0;
            point_pulse   <= 1'b0;
            scorer        <= 1'b0;
            serve_dir     <= 1'b0;
            rally_cnt     <= '0;
        end else begin
            point_pulse <= 1'b0;
            case (state)
                WAIT_FSYNC: begin
                    if (fsync) state <= TRACK;
                end
                TRACK: begin
                    // Bottom row is tested first; a hit ends tracking for this frame.
                    if (at_bot || at_top) begin
                        if ((at_bot && active_paddle_bot) || (!at_bot && active_paddle_top)) begin
                            if (rally_cnt != '1) rally_cnt <= rally_cnt + RALLY_W'(1);
                            state <= WAIT_FSYNC;
                        end else begin
                            pend_scorer <= at_bot ? P1 : P2;
                            state       <= PASSING;
                        end
                    end
                end
                PASSING: begin
                    if (!active_obj || fsync) begin
                        point_pulse <= 1'b1;
                        scorer      <= pend_scorer;
                        serve_dir   <= ~pend_scorer;
                        rally_cnt   <= '0;
                        game_over   <= 1'b1;
                        if (pend_scorer == P1) player1_score <= score_nxt;
                        else                   player2_score <= score_nxt;
                        if (score_nxt == WIN) begin
                            match_over <= 1'b1;
                            state      <= MATCH_OVER;
                        end else begin
                            state <= POINT_PAUSE;
                        end
                    end
                end
                POINT_PAUSE: begin
                    if (timer_done) begin
                        game_over <= 1'b0;
                        state     <= WAIT_FSYNC;
                    end
                end
                MATCH_OVER: begin
                    if (timer_done) begin
                        player1_score <= '0;
                        player2_score <= '0;
                        serve_dir     <= 1'b0;
                        game_over     <= 1'b0;
                        match_over    <= 1'b0;
                        state         <= WAIT_FSYNC;
                    end
                end
                default: state <= WAIT_FSYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_referee.sv
// Directed bench for pong_referee: hits, misses on both rows, pause length,
// match win and hold, async reset mid-pause and rally saturation.
module tb_pong_referee;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b0;
    logic               fsync = 1'b0;
    logic signed [11:0] vpos = '0;
    logic               active_obj = 1'b0;
    logic               active_paddle_top = 1'b0;
    logic               active_paddle_bot = 1'b0;
    logic               game_over;
    logic               match_over;
    logic [3:0]         player1_score;
    logic [3:0]         player2_score;
    logic               point_pulse;
    logic               scorer;
    logic               serve_dir;
    logic [1:0]         rally_cnt;

    int tests = 0;
    int fails = 0;
    int pulse_cnt = 0;

    pong_referee #(
        .VRES              (720),
        .PADDLE_H          (20),
        .VPOS_W            (12),
        .SCORE_W           (4),
        .WIN_SCORE         (2),
        .PAUSE_FRAMES      (128),
        .MATCH_HOLD_FRAMES (256),
        .RALLY_W           (2)
    ) dut (
        .pixel_clk         (pixel_clk),
        .rst               (rst),
        .fsync             (fsync),
        .vpos              (vpos),
        .active_obj        (active_obj),
        .active_paddle_top (active_paddle_top),
        .active_paddle_bot (active_paddle_bot),
        .game_over         (game_over),
        .match_over        (match_over),
        .player1_score     (player1_score),
        .player2_score     (player2_score),
        .point_pulse       (point_pulse),
        .scorer            (scorer),
        .serve_dir         (serve_dir),
        .rally_cnt         (rally_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(negedge pixel_clk) if (point_pulse === 1'b1) pulse_cnt++;

    task automatic step(input int v, input logic o, input logic pt, input logic pb, input logic f);
        @(negedge pixel_clk);
        vpos              = 12'(v);
        active_obj        = o;
        active_paddle_top = pt;
        active_paddle_bot = pb;
        fsync             = f;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            step(0, 1'b0, 1'b0, 1'b0, 1'b1);
            step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        rst = 1'b1;
        vpos = '0; active_obj = 1'b0; active_paddle_top = 1'b0; active_paddle_bot = 1'b0; fsync = 1'b0;
        @(negedge pixel_clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        tests++; if ({game_over, match_over, point_pulse, scorer, serve_dir} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000", {game_over, match_over, point_pulse, scorer, serve_dir});
        end
        tests++; if ({player1_score, player2_score, rally_cnt} !== 10'd0) begin
            fails++; $display("FAIL reset_counts: got p1=%0d p2=%0d rally=%0d expected 0", player1_score, player2_score, rally_cnt);
        end
        @(negedge pixel_clk);
        rst = 1'b0;
    endtask

    task automatic test_hit_bottom();
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(-700, 1'b1, 1'b0, 1'b1, 1'b0);
        tests++; if (rally_cnt !== 2'd0) begin
            fails++; $display("FAIL hit_negative_vpos: rally got %0d expected 0", rally_cnt);
        end
        step(700, 1'b1, 1'b0, 1'b1, 1'b0);
        tests++; if (rally_cnt !== 2'd1 || point_pulse !== 1'b0) begin
            fails++; $display("FAIL hit_bottom: rally=%0d pulse=%b expected 1,0", rally_cnt, point_pulse);
        end
        step(700, 1'b1, 1'b0, 1'b1, 1'b0);
        tests++; if (rally_cnt !== 2'd1 || player1_score !== 4'd0 || player2_score !== 4'd0) begin
            fails++; $display("FAIL hit_once_per_frame: rally=%0d p1=%0d p2=%0d expected 1,0,0", rally_cnt, player1_score, player2_score);
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_miss_bottom();
        int p0;
        do_reset();
        p0 = pulse_cnt;
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(700, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (point_pulse !== 1'b0 || game_over !== 1'b0) begin
            fails++; $display("FAIL miss_bot_early: pulse=%b game_over=%b expected 0,0", point_pulse, game_over);
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (point_pulse !== 1'b1 || scorer !== 1'b0 || player1_score !== 4'd1 || serve_dir !== 1'b1 || game_over !== 1'b1) begin
            fails++; $display("FAIL miss_bot_award: pulse=%b scorer=%b p1=%0d serve=%b go=%b expected 1,0,1,1,1",
                              point_pulse, scorer, player1_score, serve_dir, game_over);
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (point_pulse !== 1'b0) begin
            fails++; $display("FAIL miss_bot_pulse_width: got %b expected 0", point_pulse);
        end
        frames(127);
        tests++; if (game_over !== 1'b1) begin
            fails++; $display("FAIL pause_127: game_over got %b expected 1", game_over);
        end
        frames(1);
        tests++; if (game_over !== 1'b0) begin
            fails++; $display("FAIL pause_128: game_over got %b expected 0", game_over);
        end
        tests++; if (pulse_cnt - p0 !== 1) begin
            fails++; $display("FAIL miss_bot_pulse_count: got %0d expected 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_miss_top();
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(20, 1'b1, 1'b0, 1'b0, 1'b0);
        step(20, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (point_pulse !== 1'b1 || scorer !== 1'b1 || player2_score !== 4'd1 || player1_score !== 4'd1 || serve_dir !== 1'b0) begin
            fails++; $display("FAIL miss_top: pulse=%b scorer=%b p1=%0d p2=%0d serve=%b expected 1,1,1,1,0",
                              point_pulse, scorer, player1_score, player2_score, serve_dir);
        end
        frames(128);
        tests++; if (game_over !== 1'b0 || match_over !== 1'b0) begin
            fails++; $display("FAIL miss_top_pause_end: go=%b mo=%b expected 0,0", game_over, match_over);
        end
    endtask

    task automatic test_no_deassert_and_reset();
        do_reset();
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(700, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(700, 1'b1, 1'b0, 1'b0, 1'b0);
        tests++; if (point_pulse !== 1'b0 || player1_score !== 4'd0) begin
            fails++; $display("FAIL no_deassert_hold: pulse=%b p1=%0d expected 0,0", point_pulse, player1_score);
        end
        step(700, 1'b1, 1'b0, 1'b0, 1'b1);
        tests++; if (point_pulse !== 1'b1 || player1_score !== 4'd1 || scorer !== 1'b0) begin
            fails++; $display("FAIL no_deassert_fsync: pulse=%b p1=%0d scorer=%b expected 1,1,0", point_pulse, player1_score, scorer);
        end
        frames(50);
        tests++; if (game_over !== 1'b1) begin
            fails++; $display("FAIL mid_pause: game_over got %b expected 1", game_over);
        end
        @(negedge pixel_clk);
        #2 rst = 1'b1;
        #1;
        tests++; if (game_over !== 1'b0 || player1_score !== 4'd0 || serve_dir !== 1'b0 || scorer !== 1'b0) begin
            fails++; $display("FAIL async_reset: go=%b p1=%0d serve=%b scorer=%b expected 0,0,0,0",
                              game_over, player1_score, serve_dir, scorer);
        end
        @(negedge pixel_clk);
        rst = 1'b0;
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(700, 1'b1, 1'b0, 1'b1, 1'b0);
        tests++; if (rally_cnt !== 2'd1 || game_over !== 1'b0) begin
            fails++; $display("FAIL after_reset_track: rally=%0d go=%b expected 1,0", rally_cnt, game_over);
        end
    endtask

    task automatic test_win();
        do_reset();
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(700, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (player1_score !== 4'd1 || match_over !== 1'b0) begin
            fails++; $display("FAIL win_first_point: p1=%0d mo=%b expected 1,0", player1_score, match_over);
        end
        frames(128);
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(700, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (player1_score !== 4'd2 || match_over !== 1'b1 || game_over !== 1'b1) begin
            fails++; $display("FAIL win_match_over: p1=%0d mo=%b go=%b expected 2,1,1", player1_score, match_over, game_over);
        end
        frames(255);
        tests++; if (player1_score !== 4'd2 || match_over !== 1'b1) begin
            fails++; $display("FAIL win_hold_255: p1=%0d mo=%b expected 2,1", player1_score, match_over);
        end
        frames(1);
        tests++; if (player1_score !== 4'd0 || match_over !== 1'b0 || game_over !== 1'b0 || serve_dir !== 1'b0) begin
            fails++; $display("FAIL win_hold_256: p1=%0d mo=%b go=%b serve=%b expected 0,0,0,0",
                              player1_score, match_over, game_over, serve_dir);
        end
    endtask

    task automatic test_rally_saturation();
        int exp_r;
        do_reset();
        step(0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(700, 1'b1, 1'b0, 1'b1, 1'b1);
        tests++; if (rally_cnt !== 2'd1) begin
            fails++; $display("FAIL rally_fsync_same_cycle: got %0d expected 1", rally_cnt);
        end
        step(700, 1'b1, 1'b0, 1'b1, 1'b0);
        tests++; if (rally_cnt !== 2'd1) begin
            fails++; $display("FAIL rally_no_double: got %0d expected 1", rally_cnt);
        end
        for (int i = 2; i <= 5; i++) begin
            step(0, 1'b0, 1'b0, 1'b0, 1'b1);
            step(20, 1'b1, 1'b1, 1'b0, 1'b0);
            exp_r = (i > 3) ? 3 : i;
            tests++; if (rally_cnt !== 2'(exp_r) || point_pulse !== 1'b0) begin
                fails++; $display("FAIL rally_hit_%0d: rally=%0d pulse=%b expected %0d,0", i, rally_cnt, point_pulse, exp_r);
            end
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hit_bottom();
        test_miss_bottom();
        test_miss_top();
        test_no_deassert_and_reset();
        test_win();
        test_rally_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pong_referee.md
Name: pong_referee

Overview:
- Parametrised match referee for the pong display pipeline; replaces the inline game-over/score logic in the top level.
- Watches object and paddle activity at the two paddle rows each frame, detects misses, awards points and runs the per-point pause.
- Adds behaviour the inline logic lacks: configurable win score with a match-over hold, rally counting, serve-direction selection, and a one-cycle point pulse.
- Sits in the pixel_clk domain beside the object and paddle blocks; its outputs drive object/paddle reset, the scoreboard and the game-over overlay.

Parameters:
VRES, 720, active lines; the bottom check row is VRES-PADDLE_H.
PADDLE_H, 20, paddle height; the top check row is PADDLE_H.
VPOS_W, 12, vpos width (signed).
SCORE_W, 4, score counter width.
WIN_SCORE, 9, score that ends the match; range 1..2^SCORE_W-1.
PAUSE_FRAMES, 128, fsyncs spent in the point pause; minimum 1.
MATCH_HOLD_FRAMES, 256, fsyncs spent in match-over before scores clear; minimum 1.
RALLY_W, 8, rally counter width.

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
fsync  in  1  one-cycle frame-start pulse
vpos  in  VPOS_W  current line (signed)
active_obj  in  1  object pixel is active
active_paddle_top  in  1  top paddle pixel is active
active_paddle_bot  in  1  bottom paddle pixel is active
game_over  out  1  high during point pause and match-over; drives object/paddle reset and the overlay
match_over  out  1  high only in MATCH_OVER
player1_score  out  SCORE_W  player 1 score
player2_score  out  SCORE_W  player 2 score
point_pulse  out  1  one-cycle pulse when a point is awarded
scorer  out  1  0 = player 1, 1 = player 2; valid from point_pulse until the next point
serve_dir  out  1  1 = serve downward, toward player 2
rally_cnt  out  RALLY_W  paddle hits in the current point

Behaviour:
- Reset (async assert, sync release): all outputs 0; state WAIT_FSYNC; frame counter 0.
- All outputs are registered.
- vpos is compared as a signed value; negative vpos never matches a check row.
- WAIT_FSYNC: on fsync, go to TRACK. Other inputs are ignored.
- TRACK, bottom row (vpos == VRES-PADDLE_H) with active_obj:
  - If active_paddle_bot: hit. rally_cnt increments, saturating at all-ones. Go to WAIT_FSYNC, so only one hit is counted per frame.
  - Otherwise: miss. Latch pending scorer = 0 (player 1). Go to PASSING.
- TRACK, top row (vpos == PADDLE_H) with active_obj:
  - If active_paddle_top: hit, handled as above.
  - Otherwise: miss. Latch pending scorer = 1 (player 2). Go to PASSING.
- TRACK, row priority: the bottom-row test is evaluated first. The rows can only coincide if VRES == 2*PADDLE_H, in which case bottom wins.
- PASSING: on the first cycle with active_obj low, or on fsync (whichever comes first), award the point:
  - point_pulse = 1 for exactly one cycle.
  - scorer updates to the pending value.
  - The scorer's score increments.
  - serve_dir = ~scorer, so the serve goes toward the player who just conceded.
  - rally_cnt clears to 0.
  - If the new score == WIN_SCORE, go to MATCH_OVER; otherwise go to POINT_PAUSE.
- Scores never exceed WIN_SCORE, so no wrap-around is possible.
- POINT_PAUSE:
  - game_over = 1.
  - The frame counter increments on each fsync.
  - On the fsync that brings the count to PAUSE_FRAMES, the counter clears, game_over falls and the state goes to WAIT_FSYNC.
  - Total pause is exactly PAUSE_FRAMES fsyncs.
- MATCH_OVER:
  - game_over = 1 and match_over = 1.
  - Runs the same fsync count up to MATCH_HOLD_FRAMES.
  - On the terminating fsync: both scores clear, serve_dir clears, game_over and match_over fall, state goes to WAIT_FSYNC.
- fsync and the row condition in the same cycle while in TRACK: the row condition wins. fsync has no effect in TRACK.
- Reset mid-pause: the pause is abandoned, scores clear and the counter clears.
- point_pulse never asserts in POINT_PAUSE, MATCH_OVER or WAIT_FSYNC.

Decomposition:
- Package pong_pkg holds:
  - ref_state_t enum: WAIT_FSYNC, TRACK, PASSING, POINT_PAUSE, MATCH_OVER.
  - player_t: P1 = 0, P2 = 1.
  - The shared default constants VRES and PADDLE_H.
- Sub-module frame_timer:
  - Parameter MAX_W; inputs clear, fsync and limit.
  - Outputs count and done. done is a one-cycle pulse on the fsync at which count reaches limit; the count self-clears at that point.
  - Used once, with limit muxed between PAUSE_FRAMES and MATCH_HOLD_FRAMES by state.

Test Plan:
- Hit, bottom paddle: fsync, then vpos = 700 with active_obj = 1 and active_paddle_bot = 1 → rally_cnt = 1, state WAIT_FSYNC, no point_pulse, scores unchanged.
- Miss, bottom row: vpos = 700, active_obj = 1, paddle low, then active_obj low 3 cycles later → one point_pulse, scorer = 0, player1_score = 1, serve_dir = 1, game_over = 1. game_over falls on the 128th subsequent fsync.
- Miss, top row: vpos = 20, active_obj = 1, active_paddle_top = 0 → player2_score increments, scorer = 1, serve_dir = 0.
- Miss with no deassert: PASSING entered and active_obj held high until fsync → the point is awarded on that fsync cycle.
- Win: with WIN_SCORE = 2, two P1 misses → match_over = 1 with player1_score = 2 held. After 256 fsyncs, scores = 0 and match_over = 0.
- Async reset in POINT_PAUSE at frame 50 → all outputs 0 immediately without a clock edge. After the next fsync the block tracks normally.
- Rally saturation: with RALLY_W = 2, five hits → rally_cnt stays at 3.
